iir_power_meter: RTL
====================

// Module: iir_power_meter
// PURPOSE
//  Sink for the complex IIR filter output stream (dv + 18-bit real/imag pair), downstream of the two iir_filter lanes.
//  Computes |y|^2 per valid sample and sums it over a fixed window of 2**Nwlog2 valid samples.
//  Emits one power result per window on a valid/ready interface for the sweep controller or capture logic.
//  Measures filter gain per DDS frequency step.
// PARAMETERS
//  Nd      18  sample width, signed two's complement, per lane
//  Nwlog2  10  log2 of window length in valid samples (window = 1024)
//  Np      2*Nd         unsigned width of |y|^2 (derived, localparam)
//  Nacc    2*Nd+Nwlog2  accumulator/result width (derived, localparam)
// PORTS
//  clk       in   1     single clock domain
//  reset     in   1     synchronous, active-high
//  dv_in     in   1     sample valid, any duty cycle (e.g. 1-in-7 heartbeat)
//  d_real    in   Nd    signed real sample
//  d_imag    in   Nd    signed imag sample
//  m_tvalid  out  1     result valid
//  m_tready  in   1     result accepted when m_tvalid && m_tready
//  m_tdata   out  Nacc  window power sum, unsigned
//  overrun   out  1     sticky: a completed window was dropped
// BEHAVIOUR
//  - Reset (sync, active-high): m_tvalid=0, m_tdata=0, overrun=0, window count=0, accumulator=0, pipeline valids=0. dv_in ignored while reset=1.
//  - Reset mid-window discards the partial sum; the next window starts at the first dv_in after reset deasserts.
//  - Stage 1 (registered): p = d_real^2 + d_imag^2, exact, Np bits; max 2**(2*Nd-1) at (-2**(Nd-1), -2**(Nd-1)).
//  - Stage 2: acc <= acc + p on each valid p. Count advances per valid p and wraps at 2**Nwlog2-1 -> 0.
//  - Last sample of window: result <= acc + p, acc <= 0 on the same edge. No overflow possible; no saturation logic.
//  - Back-to-back windows: a first sample of the next window in the cycle after the last sample accumulates into the cleared acc. Zero dead cycles.
//  - Latency: m_tvalid rises 3 clk edges after the edge that sampled the window's final dv_in.
//  - Handshake: m_tvalid stays high and m_tdata stays stable until m_tready. Cleared on the transfer edge.
//  - Window completes while m_tvalid=1 and no transfer on that edge: new result dropped, old result retained, overrun <= 1 (sticky until reset).
//  - Window completes on the same edge as a transfer: new result loaded, m_tvalid stays 1, no overrun.
//  - m_tready is ignored while m_tvalid=0.
// CONFIGURATION
//  IIR_POWER_METER_PEAK_EN defined: adds output m_tpeak [Np-1:0], the max p within the window.
//   - m_tpeak is loaded, held and handshaked together with m_tdata. Its reset value is 0.
//   - The peak tracker restarts on the first sample of each window.
//  IIR_POWER_METER_PEAK_EN undefined: no m_tpeak port, no compare logic. All other behaviour is identical.
// STRUCTURE
//  - Package iir_meter_pkg holds:
//    - the width localparams/functions (Np, Nacc from Nd, Nwlog2);
//    - typedef sample_t = logic signed [Nd-1:0];
//    - typedef power_t = logic [Np-1:0].
//  - Sub-module iir_cmag2: registered complex magnitude-squared (d_real, d_imag, dv -> p, pv), 1-cycle latency.
//  - The top level holds the counter, accumulator, output register, handshake and overrun logic.
// TESTING  (Nd=18, Nwlog2=4, window 16)
//  1. Constant real=16384, imag=0, dv every cycle, m_tready=1 -> m_tdata=0x1_0000_0000 per window; first m_tvalid 3 clocks after 16th dv.
//  2. real=imag=-131072 for 16 samples -> m_tdata=2**39 (0x80_0000_0000), exact, no wrap.
//  3. Same as 1 but dv_in 1-in-7 -> identical m_tdata. m_tvalid cadence every 112 clocks.
//  4. m_tready=0 across two windows -> first result held stable, overrun=1 after second window ends. m_tready=1 then transfers the first result only.
//  5. reset pulse after 9 samples, then 16 samples of real=1 -> m_tdata=16 and overrun=0. No result emitted from the partial window.
//  6. (PEAK_EN) one sample real=1000 among 15 samples real=10 -> m_tpeak=1_000_000 and m_tdata=1_001_500.

Source files
------------

// File: rtl/iir_meter_pkg.sv
// iir_meter_pkg
//   Shared widths and types for the complex IIR power meter.
//   Nd      : sample width per lane (signed)
//   Nwlog2  : log2 of the window length in valid samples
//   Np      : width of |y|^2, exact for any pair of Nd-bit samples
//   Nacc    : width of a full-window sum, wide enough that it can never wrap
//   Helper functions let parameterized modules derive Np/Nacc from their
//   own Nd/Nwlog2 overrides.
package iir_meter_pkg;

  localparam int Nd     = 18;
  localparam int Nwlog2 = 10;

  function automatic int np_width(input int nd);
    return 2 * nd;
  endfunction

  function automatic int nacc_width(input int nd, input int nwlog2);
    return 2 * nd + nwlog2;
  endfunction

  localparam int Np   = np_width(Nd);
  localparam int Nacc = nacc_width(Nd, Nwlog2);

  typedef logic signed [Nd-1:0] sample_t;
  typedef logic [Np-1:0]        power_t;

endpackage

// File: rtl/iir_cmag2.sv
// iir_cmag2
//   Registered complex magnitude-squared: p = d_real^2 + d_imag^2, one cycle
//   of latency, with the valid flag travelling alongside the data.
//   Ports:
//     clk, reset      : clock, synchronous active-high reset
//     dv              : input sample valid
//     d_real, d_imag  : signed Nd-bit sample pair
//     p               : unsigned 2*Nd-bit power, exact
//     pv              : p is valid
module iir_cmag2
  import iir_meter_pkg::*;
#(
  parameter int Nd = 18
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dv,
  input  logic signed [Nd-1:0] d_real,
  input  logic signed [Nd-1:0] d_imag,
  output logic [2*Nd-1:0]      p,
  output logic                 pv
);

  logic signed [2*Nd-1:0] re_ext;
  logic signed [2*Nd-1:0] im_ext;
  logic signed [2*Nd-1:0] re_sq;
  logic signed [2*Nd-1:0] im_sq;

  // Sign-extend before squaring so the products are formed at full width;
  // each square is non-negative and at most 2**(2*Nd-2), so their sum fits
  // in 2*Nd unsigned bits even at the (-max, -max) corner.
  always_comb begin
    re_ext = {{Nd{d_real[Nd-1]}}, d_real};
    im_ext = {{Nd{d_imag[Nd-1]}}, d_imag};
    re_sq  = re_ext * re_ext;
    im_sq  = im_ext * im_ext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p  <= '0;
      pv <= 1'b0;
    end else begin
      p  <= $unsigned(re_sq) + $unsigned(im_sq);
      pv <= dv;
    end
  end

endmodule

// File: rtl/iir_power_meter.sv
// iir_power_meter
//   Sums |y|^2 of the complex IIR output stream over windows of 2**Nwlog2
//   valid samples and presents one result per window on a valid/ready port.
//   Pipeline: input register -> iir_cmag2 -> accumulator -> output register,
//   so m_tvalid rises three edges after the edge that took the final sample.
//   Ports:
//     clk, reset          : clock, synchronous active-high reset
//     dv_in               : sample valid, any duty cycle
//     d_real, d_imag      : signed Nd-bit sample pair
//     m_tvalid/m_tready   : result handshake
//     m_tdata             : window power sum (unsigned, Nacc bits)
//     overrun             : sticky, a completed window was dropped
//     m_tpeak             : largest |y|^2 in the window (only when
//                           IIR_POWER_METER_PEAK_EN is defined)
module iir_power_meter
  import iir_meter_pkg::*;
#(
  parameter  int Nd     = 18,
  parameter  int Nwlog2 = 10,
  localparam int Np     = np_width(Nd),
  localparam int Nacc   = nacc_width(Nd, Nwlog2)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dv_in,
  input  logic signed [Nd-1:0] d_real,
  input  logic signed [Nd-1:0] d_imag,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [Nacc-1:0]      m_tdata,
  output logic                 overrun
`ifdef IIR_POWER_METER_PEAK_EN
  ,
  output logic [Np-1:0]        m_tpeak
`endif
);

  logic                 in_v;
  logic signed [Nd-1:0] in_re;
  logic signed [Nd-1:0] in_im;
  logic [Np-1:0]        p;
  logic                 pv;
  logic [Nwlog2-1:0]    count;
  logic [Nacc-1:0]      acc;
  logic [Nacc-1:0]      acc_next;
  logic [Nacc-1:0]      sum;
  logic                 sum_v;
  logic                 last;

  // Input register isolates the multiplier from upstream routing; dv_in is
  // dropped here while reset is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_v  <= 1'b0;
      in_re <= '0;
      in_im <= '0;
    end else begin
      in_v  <= dv_in;
      in_re <= d_real;
      in_im <= d_imag;
    end
  end

  iir_cmag2 #(.Nd(Nd)) u_cmag2 (
    .clk    (clk),
    .reset  (reset),
    .dv     (in_v),
    .d_real (in_re),
    .d_imag (in_im),
    .p      (p),
    .pv     (pv)
  );

  always_comb begin
    last     = &count;
    acc_next = acc + {{Nwlog2{1'b0}}, p};
  end

`ifdef IIR_POWER_METER_PEAK_EN
  logic [Np-1:0] peak;
  logic [Np-1:0] peak_next;
  logic [Np-1:0] sum_peak;

  // The first sample of a window restarts the tracker rather than comparing
  // against the previous window's leftover maximum.
  always_comb begin
    peak_next = p;
    if (count != '0 && peak > p)
      peak_next = peak;
  end
`endif

  // Accumulator: on the last sample the completed sum is handed off and the
  // accumulator clears on the same edge, so a sample on the very next cycle
  // already belongs to the new window.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      count <= '0;
      sum   <= '0;
      sum_v <= 1'b0;
`ifdef IIR_POWER_METER_PEAK_EN
      peak     <= '0;
      sum_peak <= '0;
`endif
    end else begin
      sum_v <= 1'b0;
      if (pv) begin
        count <= count + 1'b1;
`ifdef IIR_POWER_METER_PEAK_EN
        peak <= peak_next;
`endif
        if (last) begin
          sum   <= acc_next;
          sum_v <= 1'b1;
          acc   <= '0;
`ifdef IIR_POWER_METER_PEAK_EN
          sum_peak <= peak_next;
`endif
        end else begin
          acc <= acc_next;
        end
      end
    end
  end

  // Output register and handshake. A result arriving while an unaccepted
  // one is still held is dropped and flagged; arriving on a transfer edge
  // it simply replaces the departing result.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      overrun  <= 1'b0;
`ifdef IIR_POWER_METER_PEAK_EN
      m_tpeak  <= '0;
`endif
    end else if (sum_v) begin
      if (m_tvalid && !m_tready) begin
        overrun <= 1'b1;
      end else begin
        m_tvalid <= 1'b1;
        m_tdata  <= sum;
`ifdef IIR_POWER_METER_PEAK_EN
        m_tpeak  <= sum_peak;
`endif
      end
    end else if (m_tvalid && m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule
